pid_hdng_ctrl: RTL and testbench
================================

// Module: pid_hdng_ctrl
// PURPOSE
//  Heading PID controller for the Knight's Tour robot; sits directly upstream of MtrDrv.
//  Converts heading error (actual vs desired) plus commanded forward speed into signed
//  11-bit lft_spd/rght_spd. Integrator, derivative history and output regs are stateful.
// PARAMETERS
//  P_COEFF   4'sh6   signed 4-bit proportional gain
//  D_COEFF   6'sh05  signed 6-bit derivative gain
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  moving     in   1   1 = robot driving; 0 = outputs zeroed, integrator cleared
//  err_vld    in   1   single-cycle strobe: new heading sample valid
//  dsrd_hdng  in   12  desired heading, signed
//  actl_hdng  in   12  actual heading (gyro), signed
//  frwrd_spd  in   10  commanded forward speed, unsigned
//  lft_spd    out  11  signed left motor speed to MtrDrv
//  rght_spd   out  11  signed right motor speed to MtrDrv
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). Reset: lft_spd=0,
//    rght_spd=0, integ=0, prev_err=0, pipe regs=0.
//  - err_raw = actl_hdng - dsrd_hdng, 12-bit modular (heading wrap free). err_sat = err_raw
//    saturated to 10-bit signed [-512,511].
//  - P_term = err_sat*P_COEFF, 14-bit signed.
//  - I_term = sign-ext(integ[15:4]) to 14 bits; integ is 16-bit signed register.
//    On err_vld&moving: integ <= integ+sext(err_sat) unless signed overflow
//    (operands same sign, result differs) -> integ holds. On !moving: integ <= 0.
//  - D_diff = err_sat - prev_err (11-bit), saturated to 7-bit [-64,63];
//    D_term = D_diff_sat*D_COEFF, sign-ext to 14. prev_err <= err_sat on err_vld.
//  - Terms use current err_sat and pre-update integ/prev_err registers.
//  - PID = P+I+D computed in 16 bits, saturated to 14-bit signed; corr = PID_sat>>>3 (11b).
//  - lft = {1'b0,frwrd_spd}+corr, rght = {1'b0,frwrd_spd}-corr, each computed in 12 bits
//    and saturated to 11-bit signed [-1024,1023].
//  - Outputs load only on err_vld&moving (hold otherwise); latency 1 edge after err_vld.
//  - !moving has priority: outputs <= 0 every cycle, regardless of err_vld.
//  - rst has priority over everything; rst mid-operation returns all state to reset values
//    on that edge; an err_vld coincident with rst is dropped.
// CONFIGURATION
//  PID_PIPE_EN defined: extra stage registers PID_sat and frwrd_spd on err_vld&moving plus a
//    valid flop; outputs update one edge later (latency 2). !moving clears stage and valid.
//  PID_PIPE_EN undefined: no extra stage, latency 1 as above.
// STRUCTURE
//  Package pid_pkg: widths (ERR_W=10, TERM_W=14, SPD_W=11, INTEG_W=16) and function
//    sat_signed(value, width) used for every saturation point.
//  One sub-module: pid_integrator (16-bit accumulate, overflow hold, clear on !moving).
// TESTING (latency per PID_PIPE_EN; run both builds)
//  1 Reset: rst=1 with err_vld=1, moving=1 -> lft_spd=rght_spd=0, integ=0.
//  2 Zero error: moving=1, frwrd=0x100, dsrd=actl=0, err_vld -> lft=rght=256.
//  3 Step: actl=0x040, dsrd=0, frwrd=0x100; first err_vld -> P=384,I=0,D=315, corr=87,
//    lft=343, rght=169; second identical err_vld -> I=4,D=0, corr=48, lft=304, rght=208.
//  4 Wrap+sat: dsrd=0x7FF, actl=0x800 -> err=+1 (not -4095); frwrd=0x3FF, actl-dsrd=+511
//    -> lft=1023 saturated, rght=1023-corr.
//  5 Integrator clamp: err=511 for 65 err_vld strobes -> integ=32704 after 64, holds at
//    32704 on 65th (no wrap negative).
//  6 moving 1->0 mid-run: next edge lft=rght=0, integ=0; err_vld while !moving ignored.

Source files
------------

// File: rtl/pid_pkg.sv
//------------------------------------------------------------------------------
// Module  : pid_pkg
// Purpose : Shared widths and the signed saturation helper for the heading PID
//           controller.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pid_pkg;

  localparam int ERR_W   = 10;  // saturated heading error
  localparam int DSAT_W  = 7;   // saturated derivative difference
  localparam int TERM_W  = 14;  // P/I/D terms and saturated PID sum
  localparam int PID_W   = 16;  // raw PID accumulation width
  localparam int SPD_W   = 11;  // motor speed outputs
  localparam int INTEG_W = 16;  // integrator register

  // Clamp a signed value into the range of a signed field of 'width' bits.
  // The caller truncates the 32-bit result to the target width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int               width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v)
      return max_v;
    else if (value < min_v)
      return min_v;
    else
      return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_integrator.sv
//------------------------------------------------------------------------------
// Module  : pid_integrator
// Purpose : 16-bit signed error accumulator. Holds its value instead of
//           wrapping on signed overflow; cleared while the robot is stopped.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pid_integrator
  import pid_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic signed [ERR_W-1:0]   i_err,
  output logic signed [INTEG_W-1:0] o_integ
);

  logic signed [INTEG_W-1:0] r_integ;
  logic signed [INTEG_W-1:0] w_err_ext;
  logic signed [INTEG_W-1:0] w_sum;
  logic                      w_ovf;

  assign w_err_ext = INTEG_W'(i_err);
  assign w_sum     = r_integ + w_err_ext;
  // Overflow: both operands share a sign that the result does not.
  assign w_ovf     = (r_integ[INTEG_W-1] == w_err_ext[INTEG_W-1]) &&
                     (w_sum[INTEG_W-1]   != r_integ[INTEG_W-1]);

  // Accumulate on each accepted sample; stopping clears, overflow holds.
  always_ff @(posedge clk) begin
    if (rst)
      r_integ <= '0;
    else if (i_clr)
      r_integ <= '0;
    else if (i_en && !w_ovf)
      r_integ <= w_sum;
  end

  assign o_integ = r_integ;

endmodule

`default_nettype wire

// File: rtl/pid_hdng_ctrl.sv
//------------------------------------------------------------------------------
// Module  : pid_hdng_ctrl
// Purpose : Heading PID controller. Turns heading error plus commanded forward
//           speed into saturated signed left/right motor speeds for MtrDrv.
//           Define PID_PIPE_EN to add a register stage after the PID sum
//           (output latency 2 instead of 1).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pid_hdng_ctrl
  import pid_pkg::*;
#(
  parameter logic signed [3:0] P_COEFF = 4'sh6,
  parameter logic signed [5:0] D_COEFF = 6'sh05
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    moving,
  input  logic                    err_vld,
  input  logic signed [11:0]      dsrd_hdng,
  input  logic signed [11:0]      actl_hdng,
  input  logic        [9:0]       frwrd_spd,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd
);

  logic signed [11:0]         w_err_raw;
  logic signed [ERR_W-1:0]    w_err_sat;
  logic signed [ERR_W:0]      w_d_diff;
  logic signed [DSAT_W-1:0]   w_d_sat;
  logic signed [TERM_W-1:0]   w_p_term;
  logic signed [TERM_W-1:0]   w_i_term;
  logic signed [TERM_W-1:0]   w_d_term;
  logic signed [PID_W-1:0]    w_pid_sum;
  logic signed [TERM_W-1:0]   w_pid_sat;
  logic signed [INTEG_W-1:0]  w_integ;
  logic signed [ERR_W-1:0]    r_prev_err;
  logic                       w_load;

  logic                       w_out_load;
  logic signed [TERM_W-1:0]   w_pid_use;
  logic        [9:0]          w_spd_use;
  logic signed [SPD_W-1:0]    w_corr;
  logic signed [11:0]         w_lft_sum;
  logic signed [11:0]         w_rght_sum;

  assign w_load = err_vld & moving;

  // Heading difference is modular in 12 bits, so wrap-around is free.
  assign w_err_raw = actl_hdng - dsrd_hdng;
  assign w_err_sat = ERR_W'(sat_signed(32'(w_err_raw), ERR_W));

  assign w_p_term  = TERM_W'(32'(w_err_sat) * 32'(P_COEFF));
  assign w_i_term  = TERM_W'($signed(w_integ[INTEG_W-1:4]));

  // Derivative uses the error stored at the previous accepted sample.
  assign w_d_diff  = (ERR_W+1)'(w_err_sat) - (ERR_W+1)'(r_prev_err);
  assign w_d_sat   = DSAT_W'(sat_signed(32'(w_d_diff), DSAT_W));
  assign w_d_term  = TERM_W'(32'(w_d_sat) * 32'(D_COEFF));

  assign w_pid_sum = PID_W'(w_p_term) + PID_W'(w_i_term) + PID_W'(w_d_term);
  assign w_pid_sat = TERM_W'(sat_signed(32'(w_pid_sum), TERM_W));

  pid_integrator u_integ (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (~moving),
    .i_en    (w_load),
    .i_err   (w_err_sat),
    .o_integ (w_integ)
  );

  // Remember the error of each accepted sample for the next derivative.
  always_ff @(posedge clk) begin
    if (rst)
      r_prev_err <= '0;
    else if (w_load)
      r_prev_err <= w_err_sat;
  end

`ifdef PID_PIPE_EN
  logic signed [TERM_W-1:0] r_pid_stg;
  logic        [9:0]        r_spd_stg;
  logic                     r_stg_vld;

  // Extra stage: capture PID sum and speed of an accepted sample.
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      r_pid_stg <= '0;
      r_spd_stg <= '0;
      r_stg_vld <= 1'b0;
    end else begin
      r_stg_vld <= err_vld;
      if (err_vld) begin
        r_pid_stg <= w_pid_sat;
        r_spd_stg <= frwrd_spd;
      end
    end
  end

  assign w_out_load = r_stg_vld & moving;
  assign w_pid_use  = r_pid_stg;
  assign w_spd_use  = r_spd_stg;
`else
  assign w_out_load = w_load;
  assign w_pid_use  = w_pid_sat;
  assign w_spd_use  = frwrd_spd;
`endif

  assign w_corr     = SPD_W'(w_pid_use >>> 3);
  assign w_lft_sum  = {2'b00, w_spd_use} + 12'(w_corr);
  assign w_rght_sum = {2'b00, w_spd_use} - 12'(w_corr);

  // Output registers: stopping forces zero, otherwise load on a new result.
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      lft_spd  <= '0;
      rght_spd <= '0;
    end else if (w_out_load) begin
      lft_spd  <= SPD_W'(sat_signed(32'(w_lft_sum), SPD_W));
      rght_spd <= SPD_W'(sat_signed(32'(w_rght_sum), SPD_W));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pid_hdng_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_pid_hdng_ctrl
// Purpose : Directed self-checking bench for pid_hdng_ctrl (both builds,
//           latency follows PID_PIPE_EN).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pid_hdng_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               moving;
  logic               err_vld;
  logic signed [11:0] dsrd_hdng;
  logic signed [11:0] actl_hdng;
  logic        [9:0]  frwrd_spd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;

  int n_checks = 0;
  int n_fail   = 0;

  pid_hdng_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .moving    (moving),
    .err_vld   (err_vld),
    .dsrd_hdng (dsrd_hdng),
    .actl_hdng (actl_hdng),
    .frwrd_spd (frwrd_spd),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle sample strobe, driven on the falling edge.
  task automatic strobe(input logic [11:0] d, input logic [11:0] a,
                        input logic [9:0] f);
    @(negedge clk);
    dsrd_hdng = d;
    actl_hdng = a;
    frwrd_spd = f;
    err_vld   = 1'b1;
    @(posedge clk);
    #1;
    err_vld   = 1'b0;
  endtask

  // Extra edge for the registered PID stage when it is built in.
  task automatic settle();
`ifdef PID_PIPE_EN
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    rst       = 1'b1;
    moving    = 1'b1;
    err_vld   = 1'b1;
    dsrd_hdng = 12'h000;
    actl_hdng = 12'h040;
    frwrd_spd = 10'h100;

    // Reset with a coincident strobe
    repeat (3) @(posedge clk);
    #1;
    check("rst_lft",   lft_spd,  0);
    check("rst_rght",  rght_spd, 0);
    check("rst_integ", dut.w_integ, 0);
    @(negedge clk);
    rst     = 1'b0;
    err_vld = 1'b0;

    // Zero error
    strobe(12'h000, 12'h000, 10'h100);
    settle();
    check("zero_lft",  lft_spd,  256);
    check("zero_rght", rght_spd, 256);

    // Step error of +64, twice
    strobe(12'h000, 12'h040, 10'h100);
    settle();
    check("step1_lft",  lft_spd,  343);
    check("step1_rght", rght_spd, 169);
    strobe(12'h000, 12'h040, 10'h100);
    settle();
    check("step2_lft",   lft_spd,  304);
    check("step2_rght",  rght_spd, 208);
    check("step2_integ", dut.w_integ, 128);

    // Outputs hold while no sample arrives
    repeat (3) @(posedge clk);
    #1;
    check("hold_lft", lft_spd, 304);

    // Heading wrap: 0x800 - 0x7FF = +1 (P=6 I=8 D=-315 corr=-38)
    strobe(12'h7FF, 12'h800, 10'h100);
    settle();
    check("wrap_lft",  lft_spd,  218);
    check("wrap_rght", rght_spd, 294);

    // Max positive error, full speed (P=3066 I=8 D=315 corr=423)
    strobe(12'h000, 12'h1FF, 10'h3FF);
    settle();
    check("satp_lft",  lft_spd,  1023);
    check("satp_rght", rght_spd, 600);

    // Error -1024 saturates to -512 (P=-3072 I=40 D=-320 corr=-419)
    strobe(12'h000, 12'hC00, 10'h000);
    settle();
    check("satn_lft",   lft_spd,  -419);
    check("satn_rght",  rght_spd, 419);
    check("satn_integ", dut.w_integ, 128);

    // Stop: outputs and integrator clear on the next edge
    @(negedge clk);
    moving = 1'b0;
    @(posedge clk);
    #1;
    check("stop_lft",   lft_spd,  0);
    check("stop_rght",  rght_spd, 0);
    check("stop_integ", dut.w_integ, 0);
    strobe(12'h000, 12'h1FF, 10'h3FF);
    settle();
    check("stop_vld_lft",   lft_spd, 0);
    check("stop_vld_integ", dut.w_integ, 0);

    // Integrator clamp at +32704
    @(negedge clk);
    moving = 1'b1;
    for (int i = 0; i < 64; i++)
      strobe(12'h000, 12'h1FF, 10'h000);
    check("clamp64_integ", dut.w_integ, 32704);
    strobe(12'h000, 12'h1FF, 10'h000);
    check("clamp65_integ", dut.w_integ, 32704);
    settle();
    check("clamp_lft",  lft_spd,  638);
    check("clamp_rght", rght_spd, -638);

    // Reset mid-run drops the coincident strobe
    @(negedge clk);
    rst       = 1'b1;
    err_vld   = 1'b1;
    dsrd_hdng = 12'h000;
    actl_hdng = 12'h040;
    frwrd_spd = 10'h100;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    err_vld = 1'b0;
    check("rst2_lft",   lft_spd,  0);
    check("rst2_integ", dut.w_integ, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_drop_lft", lft_spd, 0);

    // Derivative history was cleared by reset
    strobe(12'h000, 12'h040, 10'h100);
    settle();
    check("post_rst_lft",  lft_spd,  343);
    check("post_rst_rght", rght_spd, 169);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
